bcd_to_binary: RTL

- Sequential converter from packed BCD to unsigned binary, using the reverse double-dabble algorithm (shift right, then subtract 3 from any digit >= 8), one bit per clock.
- Inverse of the display-path binary-to-BCD conversion. Used where decimal-entered values (keypad/switch digits) must become binary counts for timers and arithmetic.
- Input side is a valid/ready handshake; output side holds the result until the consumer acknowledges it.

---
 rtl/bcd_to_binary.sv | 121 ++++++++++++
 1 files changed

// File: rtl/bcd_to_binary.sv
// Packed BCD to unsigned binary converter, one bit per clock, using reverse
// double-dabble: shift {bcd, bin} right, then subtract 3 from each BCD digit
// that reads >= 8. Valid/ready on input, result held until acknowledged.
module bcd_to_binary #(
    parameter int DIGITS = 8,
    parameter int BIN_W  = 27
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [BCD_W-1:0]  bcd_q;
    logic [BIN_W-1:0]  bin_q;
    logic [BCD_W-1:0]  bcd_shift;
    logic [BCD_W-1:0]  bcd_nxt;
    logic [BIN_W-1:0]  bin_nxt;

    // Subtract 3 from every digit that reads >= 8 after the shift; digits are
    // corrected independently, no borrow crosses a digit boundary.
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] d);
        logic [BCD_W-1:0] r;
        logic [3:0]       nib;
        r = d;
        for (int i = 0; i < DIGITS; i++) begin
            nib = d[4*i +: 4];
            if (nib >= 4'd8) begin
                r[4*i +: 4] = nib - 4'd3;
            end
        end
        return r;
    endfunction

    // True when any nibble holds a non-decimal code (A..F).
    function automatic logic has_bad_digit(input logic [BCD_W-1:0] d);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (d[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // One iteration: BCD LSB drops into the binary MSB, then digits are fixed up.
    always_comb begin
        bcd_shift = {1'b0, bcd_q[BCD_W-1:1]};
        bin_nxt   = {bcd_q[0], bin_q[BIN_W-1:1]};
        bcd_nxt   = dabble_adjust(bcd_shift);
    end

    // Control FSM with registered result and error outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bcd_q   <= '0;
            bin_q   <= '0;
            bin_out <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bcd_q <= bcd_in;
                        bin_q <= '0;
                        cnt   <= '0;
                        if (has_bad_digit(bcd_in)) begin
                            err     <= 1'b1;
                            bin_out <= '0;
                            state   <= DONE;
                        end else begin
                            err   <= 1'b0;
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    bcd_q <= bcd_nxt;
                    bin_q <= bin_nxt;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_ITER) begin
                        bin_out <= bin_nxt;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
